// File: rtl/cfg_frame_pkg.sv
// Shared constants, header field helpers and FSM state encoding for the
// configuration frame writer.
package cfg_frame_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned FIELD_W   = 8;
    localparam int unsigned COL_LSB   = 24;
    localparam int unsigned FRAME_LSB = 16;

    localparam logic [WORD_W-1:0]  SYNC_WORD = 32'hFAB0_FAB1;
    localparam logic [FIELD_W-1:0] END_COL   = 8'hFF;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        HDR    = 3'd1,
        DATA   = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    function automatic logic [FIELD_W-1:0] hdr_col(input logic [WORD_W-1:0] w);
        return w[COL_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] hdr_frame(input logic [WORD_W-1:0] w);
        return w[FRAME_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/config_frame_writer_if.sv
// Configuration word stream with valid/ready handshake from the bitstream loader.
interface config_frame_writer_if;
    import cfg_frame_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/frame_strobe_dec.sv
// Registered one-hot decode of (col, frame) onto the fabric latch-enable lines.
module frame_strobe_dec
    import cfg_frame_pkg::*;
#(
    parameter int unsigned COLS   = 4,
    parameter int unsigned FRAMES = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FIELD_W-1:0]       col,
    input  logic [FIELD_W-1:0]       frame,
    input  logic                     en,
    output logic [COLS*FRAMES-1:0]   strobe
);

    logic [COLS*FRAMES-1:0] strobe_d;

    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int f = 0; f < FRAMES; f++) begin
                strobe_d[c*FRAMES + f] = en && (col == FIELD_W'(c)) && (frame == FIELD_W'(f));
            end
        end
    end

    // Async clear so a reset mid-pulse drops the latch enables at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe <= '0;
        end else begin
            strobe <= strobe_d;
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Parses SYNC/header/data word stream, assembles per-row FrameData and fires
// one FrameStrobe pulse per frame with a cycle of setup and hold around it.
module config_frame_writer
    import cfg_frame_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned FRAMES = 20
) (
    input  logic                     CLK,
    input  logic                     resetn,
    config_frame_writer_if.slave     s,
    output logic [WORD_W*ROWS-1:0]   FrameData,
    output logic [COLS*FRAMES-1:0]   FrameStrobe,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FIELD_W-1:0] col_q;
    logic [FIELD_W-1:0] frame_q;
    logic               live;
    logic               accept;
    logic [FIELD_W-1:0] in_col;
    logic [FIELD_W-1:0] in_frame;
    logic               hdr_bad;

    // live holds in_ready low during reset and releases it on the first edge after.
    assign s.in_ready = live && ((state == HUNT) || (state == HDR) || (state == DATA));
    assign accept     = s.in_valid && s.in_ready;
    assign in_col     = hdr_col(s.in_data);
    assign in_frame   = hdr_frame(s.in_data);
    assign hdr_bad    = (32'(in_col) >= COLS) || (32'(in_frame) >= FRAMES);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state     <= HUNT;
            cnt       <= '0;
            col_q     <= '0;
            frame_q   <= '0;
            FrameData <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            done <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept && (s.in_data == SYNC_WORD)) begin
                        state <= HDR;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (in_col == END_COL) begin
                            state <= HUNT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (hdr_bad) begin
                            state <= HUNT;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            col_q   <= in_col;
                            frame_q <= in_frame;
                            cnt     <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Raw data words; SYNC/END values carry no meaning here.
                    if (accept) begin
                        for (int r = 0; r < ROWS; r++) begin
                            if (cnt == CNT_W'(r)) begin
                                FrameData[WORD_W*r +: WORD_W] <= s.in_data;
                            end
                        end
                        if (cnt == CNT_W'(ROWS - 1)) begin
                            state <= SETUP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                SETUP:   state <= STROBE;
                STROBE:  state <= HOLD;
                HOLD:    state <= HDR;
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Enabled during SETUP so the registered pulse lands in the STROBE cycle.
    frame_strobe_dec #(
        .COLS   (COLS),
        .FRAMES (FRAMES)
    ) u_strobe_dec (
        .clk    (CLK),
        .rst_n  (resetn),
        .col    (col_q),
        .frame  (frame_q),
        .en     (state == SETUP),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench: drivers queue expected strobe/done/err events, a negedge
// monitor pops and compares them as the writer emits them.
module tb_config_frame_writer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int FRAMES = 20;
    localparam int NS = COLS * FRAMES;

    localparam int EV_STROBE = 0;
    localparam int EV_DONE   = 1;
    localparam int EV_ERR    = 2;

    typedef struct {
        int           kind;
        int           idx;
        logic [127:0] data;
        int           gap;
    } ev_t;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [127:0]   FrameData;
    logic [NS-1:0]  FrameStrobe;
    logic           busy, done, err;

    config_frame_writer_if s();

    config_frame_writer #(.ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES)) dut (
        .CLK         (clk),
        .resetn      (resetn),
        .s           (s.slave),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    int   cyc = 0;
    bit   gaps_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input int c, input int f);
        logic [7:0] cb;
        logic [7:0] fb;
        cb = 8'(c);
        fb = 8'(f);
        return {cb, fb, 16'h5A5A};
    endfunction

    // ---------------- monitor ----------------
    logic [127:0] prev_data = '0;
    logic         prev_ready = 1'b0;
    logic         prev_err = 1'b0;
    bit           strobe_prev = 0;
    int           last_strobe_cyc = 0;

    task automatic pop_cmp(input ev_t obs);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", 128'(obs.kind), 128'hFFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 128'(obs.kind), 128'(e.kind));
            if (e.kind == EV_STROBE && obs.kind == EV_STROBE) begin
                chk("strobe_index", 128'(obs.idx), 128'(e.idx));
                chk("frame_data", obs.data, e.data);
                if (e.gap != 0) chk("strobe_gap", 128'(obs.gap), 128'(e.gap));
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t o;
        if (resetn) begin
            if (FrameStrobe != '0) begin
                chk("strobe_width", 128'(strobe_prev), 128'(0));
                chk("strobe_onehot", 128'($countones(FrameStrobe)), 128'(1));
                chk("data_setup", FrameData, prev_data);
                chk("ready_setup", 128'(prev_ready), 128'(0));
                chk("ready_strobe", 128'(s.in_ready), 128'(0));
                o.kind = EV_STROBE;
                o.idx = -1;
                for (int i = 0; i < NS; i++) if (FrameStrobe[i]) o.idx = i;
                o.data = FrameData;
                o.gap = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
                pop_cmp(o);
                strobe_prev = 1;
            end else if (strobe_prev) begin
                chk("data_hold", FrameData, prev_data);
                chk("ready_hold", 128'(s.in_ready), 128'(0));
                strobe_prev = 0;
            end
            if (done) begin
                o.kind = EV_DONE; o.idx = 0; o.data = '0; o.gap = 0;
                pop_cmp(o);
            end
            if (err && !prev_err) begin
                o.kind = EV_ERR; o.idx = 0; o.data = '0; o.gap = 0;
                pop_cmp(o);
            end
        end else begin
            strobe_prev = 0;
        end
        prev_data  = FrameData;
        prev_ready = s.in_ready;
        prev_err   = err;
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [31:0] w);
        logic acc;
        int   n;
        if (gaps_on) begin
            s.in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
        end
        s.in_data  = w;
        s.in_valid = 1'b1;
        n = 0;
        forever begin
            acc = s.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        s.in_valid = 1'b0;
    endtask

    task automatic push_ev(input int kind, input int idx, input logic [127:0] d, input int gap);
        ev_t e;
        e.kind = kind; e.idx = idx; e.data = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int c, input int f, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input int gap);
        push_ev(EV_STROBE, c * FRAMES + f, {d3, d2, d1, d0}, gap);
        send(hdr(c, f));
        send(d0); send(d1); send(d2); send(d3);
    endtask

    task automatic send_end();
        push_ev(EV_DONE, 0, '0, 0);
        send(hdr(255, 0));
    endtask

    task automatic idle(input int n);
        s.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        s.in_data  = '0;
        s.in_valid = 1'b0;
        #2;
        chk("rst_ready", 128'(s.in_ready), 128'(0));
        chk("rst_data", FrameData, 128'(0));
        chk("rst_strobe", 128'(FrameStrobe), 128'(0));
        chk("rst_flags", {125'(0), busy, done, err}, 128'(0));
        @(posedge clk);
        #1;
        chk("rst_ready_held", 128'(s.in_ready), 128'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 128'(s.in_ready), 128'(1));
        chk("busy_idle", 128'(busy), 128'(0));

        // basic frame col1/frame3 -> bit 23
        send(32'hFAB0_FAB1);
        chk("busy_after_sync", 128'(busy), 128'(1));
        send_frame(1, 3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0);
        send_end();
        #1;
        chk("done_level", 128'(done), 128'(1));
        chk("busy_after_end", 128'(busy), 128'(0));
        idle(3);

        // back-to-back (0,0) then (3,19) with no gaps
        send(32'hFAB0_FAB1);
        send_frame(0, 0, 32'hA0A0_0001, 32'hA0A0_0002, 32'hFAB0_FAB1, 32'hFF00_0000, 0);
        send_frame(3, 19, 32'hB0B0_0001, 32'hB0B0_0002, 32'hB0B0_0003, 32'hB0B0_0004, ROWS + 4);
        send_end();
        idle(3);

        // garbage before SYNC
        send(32'hDEAD_BEEF);
        send(32'h0000_0000);
        chk("garbage_busy", 128'(busy), 128'(0));
        chk("garbage_err", 128'(err), 128'(0));
        send(32'hFAB0_FAB1);
        send_frame(2, 5, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 0);
        send_end();
        idle(3);

        // bad header col=4, then SYNC clears err, then frame=20, then SYNC inside HDR
        send(32'hFAB0_FAB1);
        push_ev(EV_ERR, 0, '0, 0);
        send(hdr(4, 0));
        idle(2);
        chk("err_sticky", 128'(err), 128'(1));
        chk("err_busy", 128'(busy), 128'(0));
        send(32'hFAB0_FAB1);
        chk("err_cleared", 128'(err), 128'(0));
        push_ev(EV_ERR, 0, '0, 0);
        send(hdr(0, 20));
        chk("err_frame", 128'(err), 128'(1));
        send(32'hFAB0_FAB1);
        push_ev(EV_ERR, 0, '0, 0);
        send(32'hFAB0_FAB1);
        chk("sync_in_hdr_err", 128'(err), 128'(1));
        idle(3);

        // random valid gaps
        gaps_on = 1;
        send(32'hFAB0_FAB1);
        send_frame(3, 0, 32'hC001_0001, 32'hC001_0002, 32'hC001_0003, 32'hC001_0004, 0);
        send_frame(0, 19, 32'h7654_3210, 32'h89AB_CDEF, 32'h0F0F_F0F0, 32'h1234_5678, 0);
        send_end();
        gaps_on = 0;
        idle(3);

        // reset during STROBE
        send(32'hFAB0_FAB1);
        send(hdr(1, 1));
        send(32'hEEEE_0001); send(32'hEEEE_0002); send(32'hEEEE_0003); send(32'hEEEE_0004);
        begin
            int n;
            n = 0;
            while (FrameStrobe == '0 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("strobe_before_reset", 128'(FrameStrobe[1 * FRAMES + 1]), 128'(1));
        end
        resetn = 1'b0;
        #1;
        chk("async_strobe_clear", 128'(FrameStrobe), 128'(0));
        chk("async_data_clear", FrameData, 128'(0));
        chk("async_busy_clear", 128'(busy), 128'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send(32'hFAB0_FAB1);
        send_frame(2, 2, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004, 0);
        send_end();
        idle(6);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
